fu_wb_port: RTL

FU_WB_PORT -- requirements
Module: fu_wb_port

---
 rtl/fu_wb_port.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fu_wb_port.sv
// Functional-unit writeback port: in-order result FIFO driving a chained ROB bus and CDB.
// Optional same-cycle bypass of an incoming result when the FIFO is empty: define FU_WB_BYPASS_EN.

package fu_wb_port_pkg;
    typedef struct packed {
        logic [3:0] robid;
        logic [7:0] flags;
        logic [7:0] wbs;
        logic [7:0] value;
    } wb_entry_t;
endpackage

module fu_wb_port
    import fu_wb_port_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [3:0] res_robid,
    input  logic [7:0] res_flags,
    input  logic [7:0] res_wbs,
    input  logic [7:0] res_value,
    input  logic       rob_transmit_in,
    output logic       rob_transmit_out,
    output logic [7:0] robid_out,
    output logic [7:0] flags_out,
    output logic [7:0] wbs_out,
    output logic [7:0] value_out,
    input  logic       cdb_transmit_in,
    output logic       cdb_transmit_out,
    output logic [3:0] cdb_id,
    output logic [7:0] cdb_val,
    output logic       busy,
    output logic       overflow_err,
    output logic [7:0] stall_cycles
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    stall_q, stall_d;
    wb_entry_t     mem_q [DEPTH];

    wb_entry_t in_entry;
    wb_entry_t head;
    wb_entry_t drv_entry;
    logic      empty;
    logic      full;
    logic      fifo_drive;
    logic      drive;
    logic      push;
    logic      bcast;

    assign in_entry = '{robid: res_robid, flags: res_flags, wbs: res_wbs, value: res_value};
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign busy      = full;
    assign res_ready = ~full;

    // rst gates the local drive so outputs fall immediately, ahead of the pointer clear.
    assign fifo_drive = rst & ~empty & ~rob_transmit_in;

`ifdef FU_WB_BYPASS_EN
    logic bypass;
    assign bypass    = rst & empty & res_valid & ~rob_transmit_in;
    assign drive     = fifo_drive | bypass;
    assign drv_entry = bypass ? in_entry : head;
    assign push      = res_valid & res_ready & ~bypass;
`else
    assign drive     = fifo_drive;
    assign drv_entry = head;
    assign push      = res_valid & res_ready;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        stall_d  = stall_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (fifo_drive) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (res_valid && full) begin
            ovf_d = 1'b1;
        end
        if (!empty && rob_transmit_in && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage needs no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
        end
    end

    assign bcast = drive & drv_entry.flags[1];

    assign rob_transmit_out = rob_transmit_in | drive;
    assign robid_out        = drive ? {4'b0000, drv_entry.robid} : 8'h00;
    assign flags_out        = drive ? drv_entry.flags : 8'h00;
    assign wbs_out          = drive ? drv_entry.wbs   : 8'h00;
    assign value_out        = drive ? drv_entry.value : 8'h00;

    assign cdb_transmit_out = cdb_transmit_in | bcast;
    assign cdb_id           = bcast ? drv_entry.wbs[3:0] : 4'h0;
    assign cdb_val          = bcast ? drv_entry.value    : 8'h00;

    assign overflow_err = ovf_q;
    assign stall_cycles = stall_q;

endmodule
